// File: rtl/mc_controller_if.sv
// Bus between the multicycle controller and its datapath.
// Carries instruction/flags in and all datapath strobes/selects out.
interface mc_controller_if #(
  parameter int ALUCTRL_W = 3
);
  logic [31:0]          Instr;
  logic [3:0]           ALUFlags;
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 MemW;
  logic                 IRWrite;
  logic                 RegW;
  logic                 ALUSrcA;
  logic [1:0]           ResultSrc;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ImmSrc;
  logic [1:0]           RegSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic                 Busy;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemW, IRWrite,
    output RegW, ALUSrcA, ResultSrc, ALUSrcB,
    output ImmSrc, RegSrc, ALUControl, Busy
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemW, IRWrite,
    input  RegW, ALUSrcA, ResultSrc, ALUSrcB,
    input  ImmSrc, RegSrc, ALUControl, Busy
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle ARM-style controller: Moore FSM, cond flags, MUL stall.
// Ports: clk, reset (async active-low), bus (mc_controller_if.master).
module mc_controller #(
  parameter int ALUCTRL_W = 3,
  parameter int MUL_LAT   = 3
) (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_MEMADR,
    S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR,
    S_EXECI, S_MULWAIT, S_ALUWB, S_BRANCH
  } state_t;

  localparam bit MUL_STALL = MUL_LAT > 1;
  localparam int CNT_W =
    (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
  localparam int CNT_INIT_I =
    (MUL_LAT > 2) ? MUL_LAT - 2 : 0;
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(CNT_INIT_I);

  localparam logic [2:0] A_ADD = 3'd0;
  localparam logic [2:0] A_SUB = 3'd1;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       flags;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic       rd15;
  logic [2:0] alu_dec;
  logic       dec_ok;
  logic       is_mul;
  logic       cond_ex;
  logic       exec;
  logic       last_exec;

  assign cond  = bus.Instr[31:28];
  assign op    = bus.Instr[27:26];
  assign funct = bus.Instr[25:20];
  assign rd15  = bus.Instr[15:12] == 4'hF;

  always_comb begin
    alu_dec = A_ADD;
    dec_ok  = 1'b1;
    case (funct[4:1])
      4'b0100: alu_dec = 3'd0;
      4'b0010: alu_dec = 3'd1;
      4'b0000: alu_dec = 3'd2;
      4'b1100: alu_dec = 3'd3;
      4'b1101: alu_dec = 3'd4;
      4'b1001: alu_dec = 3'd5;
      4'b1011: alu_dec = 3'd6;
      default: dec_ok  = 1'b0;
    endcase
  end

  assign is_mul = funct[4:1] == 4'b1001;

  // flags = {N,Z,C,V}
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flags[2];
      4'b0001: cond_ex = !flags[2];
      4'b0010: cond_ex = flags[1];
      4'b0011: cond_ex = !flags[1];
      4'b0100: cond_ex = flags[3];
      4'b0101: cond_ex = !flags[3];
      4'b0110: cond_ex = flags[0];
      4'b0111: cond_ex = !flags[0];
      4'b1000: cond_ex = flags[1] && !flags[2];
      4'b1001: cond_ex = !flags[1] || flags[2];
      4'b1010: cond_ex = flags[3] == flags[0];
      4'b1011: cond_ex = flags[3] != flags[0];
      4'b1100: cond_ex = !flags[2] &&
                         (flags[3] == flags[0]);
      4'b1101: cond_ex = flags[2] ||
                         (flags[3] != flags[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign exec = (state == S_EXECR) ||
                (state == S_EXECI);

  // Final execute cycle: where the flags get captured.
  assign last_exec =
    (exec && !(is_mul && MUL_STALL)) ||
    ((state == S_MULWAIT) && (cnt == '0));

  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:   state_nx = S_FETCH;
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b01:   state_nx = S_MEMADR;
          2'b00:   state_nx = funct[5] ? S_EXECI
                                       : S_EXECR;
          2'b10:   state_nx = S_BRANCH;
          default: state_nx = S_FETCH;
        endcase
      end
      S_MEMADR: state_nx = funct[0] ? S_MEMRD
                                    : S_MEMWR;
      S_MEMRD:  state_nx = S_MEMWB;
      S_EXECR,
      S_EXECI:  state_nx = (is_mul && MUL_STALL)
                           ? S_MULWAIT : S_ALUWB;
      S_MULWAIT:
        state_nx = (cnt == '0) ? S_ALUWB
                               : S_MULWAIT;
      default:  state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_INIT;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (exec &&
                 state_nx == S_MULWAIT) begin
      cnt <= CNT_INIT;
    end else if (state == S_MULWAIT &&
                 cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags <= 4'b0000;
    end else if (last_exec && cond_ex &&
                 funct[0] && dec_ok) begin
      flags[3:2] <= bus.ALUFlags[3:2];
      if (alu_dec == A_ADD || alu_dec == A_SUB)
        flags[1:0] <= bus.ALUFlags[1:0];
    end
  end

  logic       next_pc;
  logic       branch;
  logic       regw_u;
  logic       memw_u;
  logic       adr_src;
  logic       ir_write;
  logic       src_a;
  logic [1:0] res_src;
  logic [1:0] src_b;
  logic [2:0] alu_sel;
  logic       busy;

  always_comb begin
    next_pc  = 1'b0;
    branch   = 1'b0;
    regw_u   = 1'b0;
    memw_u   = 1'b0;
    adr_src  = 1'b0;
    ir_write = 1'b0;
    src_a    = 1'b0;
    res_src  = 2'b00;
    src_b    = 2'b00;
    alu_sel  = A_ADD;
    busy     = 1'b0;
    case (state)
      S_FETCH: begin
        ir_write = 1'b1;
        src_a    = 1'b1;
        src_b    = 2'b10;
        res_src  = 2'b10;
        next_pc  = 1'b1;
      end
      S_DECODE: begin
        src_a   = 1'b1;
        src_b   = 2'b10;
        res_src = 2'b10;
      end
      S_MEMADR: src_b = 2'b01;
      S_MEMRD:  adr_src = 1'b1;
      S_MEMWB: begin
        res_src = 2'b01;
        regw_u  = 1'b1;
      end
      S_MEMWR: begin
        adr_src = 1'b1;
        memw_u  = 1'b1;
      end
      S_EXECR:  alu_sel = alu_dec;
      S_MULWAIT: begin
        alu_sel = alu_dec;
        busy    = 1'b1;
      end
      S_EXECI: begin
        src_b   = 2'b01;
        alu_sel = alu_dec;
      end
      S_ALUWB:  regw_u = dec_ok;
      S_BRANCH: begin
        src_b   = 2'b01;
        res_src = 2'b10;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.RegW      = regw_u & cond_ex;
  assign bus.MemW      = memw_u & cond_ex;
  assign bus.PCWrite   = next_pc |
                         (branch & cond_ex) |
                         (regw_u & cond_ex & rd15);
  assign bus.AdrSrc    = adr_src;
  assign bus.IRWrite   = ir_write;
  assign bus.ALUSrcA   = src_a;
  assign bus.ResultSrc = res_src;
  assign bus.ALUSrcB   = src_b;
  assign bus.ALUControl = ALUCTRL_W'(alu_sel);
  assign bus.Busy      = busy;

  assign bus.ImmSrc = (state == S_INIT) ? 2'b00
                                        : op;
  assign bus.RegSrc = (state == S_INIT) ? 2'b00
                    : {op == 2'b01, op == 2'b10};

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller against an instruction-level model.
// Also runs a MUL_LAT=1 instance through one directed MUL.
module tb_mc_controller;

  localparam int LAT = 3;

  localparam int PF  = 0;
  localparam int PD  = 1;
  localparam int PMA = 2;
  localparam int PMR = 3;
  localparam int PMB = 4;
  localparam int PMW = 5;
  localparam int PXR = 6;
  localparam int PXI = 7;
  localparam int PW  = 8;
  localparam int PA  = 9;
  localparam int PBR = 10;

  localparam logic [3:0] OPS [7] = '{
    4'b0100, 4'b0010, 4'b0000, 4'b1100,
    4'b1101, 4'b1001, 4'b1011
  };

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic       regw;
    logic       srca;
    logic [1:0] res;
    logic [1:0] srcb;
    logic [1:0] imm;
    logic [1:0] regsrc;
    logic [2:0] alu;
    logic       busy;
  } ov_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst1 = 1'b0;
  always #5 clk = ~clk;

  mc_controller_if #(.ALUCTRL_W(3)) bus ();
  mc_controller_if #(.ALUCTRL_W(3)) bus1 ();

  mc_controller #(
    .ALUCTRL_W(3), .MUL_LAT(LAT)
  ) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  mc_controller #(
    .ALUCTRL_W(3), .MUL_LAT(1)
  ) dut1 (
    .clk(clk), .reset(rst1), .bus(bus1)
  );

  ov_t act;
  ov_t act1;
  assign act = {
    bus.PCWrite, bus.AdrSrc, bus.MemW,
    bus.IRWrite, bus.RegW, bus.ALUSrcA,
    bus.ResultSrc, bus.ALUSrcB, bus.ImmSrc,
    bus.RegSrc, bus.ALUControl, bus.Busy
  };
  assign act1 = {
    bus1.PCWrite, bus1.AdrSrc, bus1.MemW,
    bus1.IRWrite, bus1.RegW, bus1.ALUSrcA,
    bus1.ResultSrc, bus1.ALUSrcB, bus1.ImmSrc,
    bus1.RegSrc, bus1.ALUControl, bus1.Busy
  };

  int  n_cmp = 0;
  int  n_bad = 0;
  ov_t exp_o;
  bit  exp_on = 1'b0;
  int  cur_ph = 0;
  ov_t cap [11];
  int  busy_n = 0;

  logic [3:0] mf = 4'b0000;
  bit         pend = 1'b0;
  logic [3:0] pend_f = 4'b0000;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_on) begin
      chk("outs", 32'(act), 32'(exp_o));
      cap[cur_ph] = act;
      if (act.busy) busy_n++;
    end
  end

  function automatic bit cond_ok(
    input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void dec(
    input logic [3:0] f4,
    output logic [2:0] code, output bit ok);
    code = 3'd0;
    ok   = 1'b0;
    for (int k = 0; k < 7; k++)
      if (OPS[k] == f4) begin
        code = 3'(k);
        ok   = 1'b1;
      end
  endfunction

  function automatic ov_t model(
    input int ph, input logic [31:0] ins,
    input logic [3:0] f);
    ov_t o;
    logic [1:0] op;
    logic [2:0] code;
    bit ok, ce, r15;
    o   = '0;
    op  = ins[27:26];
    ce  = cond_ok(ins[31:28], f);
    r15 = ins[15:12] == 4'hF;
    dec(ins[24:21], code, ok);
    o.imm    = op;
    o.regsrc = {op == 2'b01, op == 2'b10};
    case (ph)
      PF: begin
        o.irw = 1; o.srca = 1; o.srcb = 2;
        o.res = 2; o.pcw = 1;
      end
      PD: begin
        o.srca = 1; o.srcb = 2; o.res = 2;
      end
      PMA: o.srcb = 1;
      PMR: o.adr = 1;
      PMB: begin
        o.res = 1; o.regw = ce; o.pcw = ce && r15;
      end
      PMW: begin
        o.adr = 1; o.memw = ce;
      end
      PXR: o.alu = code;
      PXI: begin
        o.srcb = 1; o.alu = code;
      end
      PW: begin
        o.alu = code; o.busy = 1;
      end
      PA: begin
        o.regw = ok && ce;
        o.pcw  = ok && ce && r15;
      end
      PBR: begin
        o.srcb = 1; o.res = 2; o.pcw = ce;
      end
      default: ;
    endcase
    return o;
  endfunction

  function automatic logic [31:0] mk(
    input logic [3:0] c, input logic [1:0] op,
    input logic [5:0] fn, input logic [3:0] rd);
    return {c, op, fn, 4'h0, rd, 12'h000};
  endfunction

  task automatic release_rst();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_o = '0;
    cur_ph = 0;
    @(negedge clk); #1;
  endtask

  task automatic run(input logic [31:0] ins,
                     input bit fix,
                     input logic [3:0] af,
                     input int abort_at);
    int ph [$];
    logic [5:0] fn;
    logic [2:0] code;
    logic [3:0] a_now;
    bit ok, mul, last;
    fn  = ins[25:20];
    dec(fn[4:1], code, ok);
    mul = fn[4:1] == 4'b1001;
    ph.push_back(PF);
    ph.push_back(PD);
    case (ins[27:26])
      2'b01: begin
        ph.push_back(PMA);
        if (fn[0]) begin
          ph.push_back(PMR);
          ph.push_back(PMB);
        end else ph.push_back(PMW);
      end
      2'b00: begin
        ph.push_back(fn[5] ? PXI : PXR);
        if (mul)
          for (int k = 1; k < LAT; k++)
            ph.push_back(PW);
        ph.push_back(PA);
      end
      2'b10: ph.push_back(PBR);
      default: ;
    endcase
    busy_n = 0;
    for (int i = 0; i < ph.size(); i++) begin
      @(posedge clk); #1;
      if (pend) begin
        mf = pend_f;
        pend = 1'b0;
      end
      if (ph[i] == PF) bus.Instr = ins;
      a_now = fix ? af : 4'($urandom);
      bus.ALUFlags = a_now;
      cur_ph = ph[i];
      exp_o = model(ph[i], ins, mf);
      last = (i + 1 < ph.size()) &&
             (ph[i + 1] == PA);
      if (last && cond_ok(ins[31:28], mf) &&
          fn[0] && ok) begin
        pend = 1'b1;
        pend_f = {a_now[3:2],
                  (code <= 3'd1) ? a_now[1:0]
                                 : mf[1:0]};
      end
      if (i == abort_at) begin
        #1;
        rst_n = 1'b0;
        mf = 4'b0000;
        pend = 1'b0;
        exp_o = '0;
        #1;
        chk("rst_outs", 32'(act), 32'd0);
        chk("rst_busy", 32'(act.busy), 32'd0);
        @(negedge clk); #1;
        return;
      end
      @(negedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [3:0] c, f4, rd;
    logic [1:0] op;
    c  = ($urandom % 4 == 0) ? 4'hE
                             : 4'($urandom);
    op = 2'($urandom);
    f4 = ($urandom % 4 == 0) ? 4'($urandom)
                             : OPS[$urandom % 7];
    rd = ($urandom % 4 == 0) ? 4'hF
                             : 4'($urandom);
    return mk(c, op,
      {1'($urandom), f4, 1'($urandom)}, rd);
  endfunction

  logic [31:0] adds, beq, mul_i;

  initial begin
    bus.Instr = '0;
    bus.ALUFlags = '0;
    bus1.Instr = mk(4'hE, 2'b00, 6'b010010, 4'h1);
    bus1.ALUFlags = '0;
    exp_o = '0;
    exp_on = 1'b1;
    adds  = mk(4'hE, 2'b00, 6'b001001, 4'h1);
    beq   = mk(4'h0, 2'b10, 6'b000000, 4'h0);
    mul_i = mk(4'hE, 2'b00, 6'b010010, 4'h2);

    release_rst();
    run(adds, 1'b1, 4'b0110, -1);
    chk("fetch_irw", 32'(cap[PF].irw), 32'd1);
    chk("fetch_pcw", 32'(cap[PF].pcw), 32'd1);
    chk("fetch_alu", 32'(cap[PF].alu), 32'd0);
    chk("adds_regw", 32'(cap[PA].regw), 32'd1);
    chk("adds_flags", 32'(mf), 32'h6);

    run(beq, 1'b0, 4'h0, -1);
    chk("beq_taken", 32'(cap[PBR].pcw), 32'd1);

    run(mul_i, 1'b0, 4'h0, -1);
    chk("mul_busy_n", 32'(busy_n), 32'd2);
    chk("mul_alu", 32'(cap[PXR].alu), 32'd5);
    chk("mul_wb", 32'(cap[PA].regw), 32'd1);

    run(adds, 1'b1, 4'b0000, -1);
    run(beq, 1'b0, 4'h0, -1);
    chk("beq_not", 32'(cap[PBR].pcw), 32'd0);

    run(mk(4'hE, 2'b01, 6'b011001, 4'hF),
        1'b0, 4'h0, -1);
    chk("ldr_regw", 32'(cap[PMB].regw), 32'd1);
    chk("ldr_pcw", 32'(cap[PMB].pcw), 32'd1);

    run(mk(4'h0, 2'b01, 6'b011000, 4'h3),
        1'b0, 4'h0, -1);
    chk("str_memw", 32'(cap[PMW].memw), 32'd0);

    run(adds, 1'b1, 4'b0100, -1);
    run(mul_i, 1'b0, 4'h0, 3);
    release_rst();
    run(mk(4'h0, 2'b00, 6'b001000, 4'h4),
        1'b0, 4'h0, -1);
    chk("flags_clr", 32'(cap[PA].regw), 32'd0);

    repeat (300) run(rnd_instr(), 1'b0, 4'h0, -1);

    exp_on = 1'b0;
    chk("u1_rst", 32'(act1), 32'd0);
    @(posedge clk); #1;
    rst1 = 1'b1;
    chk("u1_init", 32'(act1), 32'd0);
    @(posedge clk); #1;
    chk("u1_fetch", 32'(act1.irw), 32'd1);
    @(posedge clk); #1;
    chk("u1_dec", 32'(act1.srcb), 32'd2);
    @(posedge clk); #1;
    chk("u1_ex_alu", 32'(act1.alu), 32'd5);
    chk("u1_ex_busy", 32'(act1.busy), 32'd0);
    @(posedge clk); #1;
    chk("u1_wb", 32'(act1.regw), 32'd1);
    @(posedge clk); #1;
    chk("u1_fetch2", 32'(act1.irw), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
